fetch_ctrl: RTL and testbench

//   Instruction-fetch sequencer that sits between the instruction cache and the decoder.
//   It owns the fetch PC and issues one icache request at a time.
//   It holds each returned instruction until the decoder accepts it.
//   It applies redirects: decoder jump/branch targets, and ROB flushes on mispredict.

---
 rtl/fetch_ctrl.sv | 119 +++++++++++
 tb/tb_fetch_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer between icache and decoder: owns the fetch PC, issues one
// icache request at a time, holds each word for the decoder and applies redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_ready,
  input  logic [31:0] ic_inst,
  output logic        dec_inst_valid,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_inst,
  input  logic        dec_need_inst,
  input  logic        dec_redirect,
  input  logic [31:0] dec_redirect_addr,
  input  logic        rob_flush,
  input  logic [31:0] rob_flush_addr
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] flush_addr_q, flush_addr_d;
  logic        redirect_s;
  logic [31:0] flush_tgt_s;

  // ROB flush outranks a decoder redirect raised in the same cycle.
  always_comb begin
    redirect_s  = rob_flush | dec_redirect;
    flush_tgt_s = dec_redirect_addr;
    if (rob_flush) begin
      flush_tgt_s = rob_flush_addr;
    end else begin
      flush_tgt_s = dec_redirect_addr;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_d        = buf_q;
    flush_addr_d = flush_addr_q;
    case (state_q)
      S_REQ: begin
        if (redirect_s) begin
          pc_d = flush_tgt_s;
          if (ic_ready) begin
            state_d = S_REQ;
          end else begin
            // wrong-path request still outstanding; keep presenting its address
            flush_addr_d = pc_q;
            state_d      = S_FLUSH;
          end
        end else if (ic_ready) begin
          buf_d   = ic_inst;
          state_d = S_HOLD;
        end else begin
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect_s) begin
          pc_d    = flush_tgt_s;
          state_d = S_REQ;
        end else if (!dec_need_inst) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_FLUSH: begin
        if (redirect_s) begin
          pc_d = flush_tgt_s;
        end else begin
          pc_d = pc_q;
        end
        if (ic_ready) begin
          state_d = S_REQ;
        end else begin
          state_d = S_FLUSH;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      buf_q        <= 32'h0;
      flush_addr_q <= RESET_PC;
    end else if (rdy) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_q        <= buf_d;
      flush_addr_q <= flush_addr_d;
    end
  end

  assign ic_req         = !rst && (state_q != S_HOLD);
  assign ic_addr        = rst ? RESET_PC : ((state_q == S_FLUSH) ? flush_addr_q : pc_q);
  assign dec_inst_valid = !rst && (state_q == S_HOLD);
  assign dec_pc         = rst ? RESET_PC : pc_q;
  assign dec_inst       = rst ? 32'h0 : buf_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: icache responder, fetch reference model, directed scenario table
// and a randomized run compared cycle by cycle against the model.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_ready = 1'b0;
  logic [31:0] ic_inst = 32'h0;
  logic        dec_inst_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;
  logic        dec_need_inst = 1'b1;
  logic        dec_redirect = 1'b0;
  logic [31:0] dec_redirect_addr = 32'h0;
  logic        rob_flush = 1'b0;
  logic [31:0] rob_flush_addr = 32'h0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_inst(ic_inst),
    .dec_inst_valid(dec_inst_valid), .dec_pc(dec_pc), .dec_inst(dec_inst),
    .dec_need_inst(dec_need_inst), .dec_redirect(dec_redirect),
    .dec_redirect_addr(dec_redirect_addr), .rob_flush(rob_flush),
    .rob_flush_addr(rob_flush_addr)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // icache responder state
  bit          ic_busy = 1'b0;
  int          ic_cnt  = 0;
  int          ic_lat  = 1;
  logic [31:0] ic_req_addr = 32'h0;

  // reference model: one word buffer plus an optional wrong-path fetch in flight
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_word = 32'h0;
  logic [31:0] m_stale_addr = 32'h0;
  bit          m_valid = 1'b0;
  bit          m_stale = 1'b0;

  bit          prev_valid = 1'b0;
  bit          flush_seen = 1'b0;
  logic [31:0] pres_pc[$];
  int          pres_cyc[$];

  typedef struct {
    int          lat;
    int          delay;
    bit          use_dec;
    logic [31:0] dec_tgt;
    bit          use_rob;
    logic [31:0] rob_tgt;
    logic [31:0] exp_pc;
    bit          exp_flush;
  } scen_t;

  scen_t tbl[4];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  task automatic icache_eval();
    if (ic_ready) ic_busy = 1'b0;
    ic_ready = 1'b0;
    ic_inst  = 32'hDEAD_BEEF;
    if (rst) begin
      ic_busy = 1'b0;
    end else begin
      if (ic_busy) begin
        chk("ic_req_held", {31'h0, ic_req}, 32'h1);
        chk("ic_addr_stable", ic_addr, ic_req_addr);
      end
      if (rdy) begin
        if (!ic_busy && ic_req) begin
          ic_busy     = 1'b1;
          ic_cnt      = ic_lat;
          ic_req_addr = ic_addr;
        end else if (ic_busy && ic_cnt > 0) begin
          ic_cnt--;
        end
        if (ic_busy && ic_cnt == 0) begin
          ic_ready = 1'b1;
          ic_inst  = mem_word(ic_req_addr);
        end
      end
    end
  endtask

  task automatic compare();
    if (rst) begin
      chk("rst_valid", {31'h0, dec_inst_valid}, 32'h0);
      chk("rst_ic_req", {31'h0, ic_req}, 32'h0);
      chk("rst_dec_pc", dec_pc, RESET_PC);
      chk("rst_ic_addr", ic_addr, RESET_PC);
      chk("rst_dec_inst", dec_inst, 32'h0);
    end else begin
      chk("dec_inst_valid", {31'h0, dec_inst_valid}, {31'h0, m_valid});
      chk("ic_req", {31'h0, ic_req}, {31'h0, !m_valid});
      chk("dec_pc", dec_pc, m_pc);
      chk("ic_addr", ic_addr, m_stale ? m_stale_addr : m_pc);
      if (m_valid) begin
        chk("dec_inst", dec_inst, m_word);
        chk("dec_inst_vs_mem", dec_inst, mem_word(m_pc));
      end
    end
    if (dec_inst_valid && !prev_valid) begin
      pres_pc.push_back(dec_pc);
      pres_cyc.push_back(cyc);
    end
    if (!rst && ic_req && ic_addr != dec_pc) flush_seen = 1'b1;
    prev_valid = dec_inst_valid;
  endtask

  task automatic model_next();
    bit          redir;
    logic [31:0] tgt;
    redir = rob_flush || dec_redirect;
    tgt   = rob_flush ? rob_flush_addr : dec_redirect_addr;
    if (rst) begin
      m_pc    = RESET_PC;
      m_valid = 1'b0;
      m_stale = 1'b0;
      m_word  = 32'h0;
    end else if (rdy) begin
      if (m_valid) begin
        if (redir) begin
          m_pc    = tgt;
          m_valid = 1'b0;
        end else if (!dec_need_inst) begin
          m_pc    = m_pc + 32'd4;
          m_valid = 1'b0;
        end
      end else if (m_stale) begin
        if (redir) m_pc = tgt;
        if (ic_ready) m_stale = 1'b0;
      end else if (redir) begin
        if (!ic_ready) begin
          m_stale      = 1'b1;
          m_stale_addr = m_pc;
        end
        m_pc = tgt;
      end else if (ic_ready) begin
        m_word  = ic_inst;
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    #1 icache_eval();
    #1 compare();
    model_next();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; rdy = 1'b1; dec_need_inst = 1'b1;
    dec_redirect = 1'b0; rob_flush = 1'b0;
    repeat (n) cycle();
    rst = 1'b0;
    pres_pc.delete();
    pres_cyc.delete();
  endtask

  task automatic wait_present(input int budget, input string name);
    int n0;
    int n;
    n0 = pres_pc.size();
    n  = 0;
    while (pres_pc.size() == n0 && n < budget) begin
      cycle();
      n++;
    end
    if (pres_pc.size() == n0) timeout(name);
  endtask

  task automatic run_to_pc(input logic [31:0] a);
    bit found;
    int n;
    found = 1'b0;
    n     = 0;
    while (!found && n < 100) begin
      if (dec_inst_valid && dec_pc == a && !dec_need_inst) found = 1'b1;
      cycle();
      n++;
    end
    if (!found) timeout("run_to_pc");
  endtask

  initial begin
    logic [31:0] ra;
    int          n0;
    tbl[0] = '{3, 1, 1'b1, 32'h40,  1'b0, 32'h0,   32'h40,  1'b1};
    tbl[1] = '{1, 2, 1'b1, 32'h40,  1'b0, 32'h0,   32'h40,  1'b0};
    tbl[2] = '{0, 1, 1'b1, 32'h40,  1'b0, 32'h0,   32'h40,  1'b0};
    tbl[3] = '{2, 1, 1'b1, 32'h80,  1'b1, 32'h200, 32'h200, 1'b1};

    // streaming with a 1-cycle icache and an always-ready decoder
    ic_lat = 1;
    do_reset(2);
    dec_need_inst = 1'b0;
    for (int k = 0; k < 4; k++) wait_present(20, "t1_word");
    if (pres_pc.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk("t1_pc", pres_pc[k], 32'(k * 4));
      for (int k = 1; k < 4; k++) chk("t1_spacing", 32'(pres_cyc[k] - pres_cyc[k-1]), 32'd3);
    end

    // decoder stall holds the word at 0x10
    dec_need_inst = 1'b1;
    wait_present(20, "t2_word");
    for (int k = 0; k < 5; k++) begin
      chk("t2_pc", dec_pc, 32'h10);
      chk("t2_inst", dec_inst, mem_word(32'h10));
      chk("t2_ic_req", {31'h0, ic_req}, 32'h0);
      chk("t2_valid", {31'h0, dec_inst_valid}, 32'h1);
      cycle();
    end
    dec_need_inst = 1'b0;
    n0 = pres_pc.size();
    wait_present(20, "t2_next");
    if (pres_pc.size() > n0) chk("t2_next_pc", pres_pc[n0], 32'h14);

    // redirect scenarios after accepting a jump at 0x10
    for (int i = 0; i < 4; i++) begin
      ic_lat = tbl[i].lat;
      do_reset(1);
      dec_need_inst = 1'b0;
      run_to_pc(32'h10);
      repeat (tbl[i].delay - 1) cycle();
      flush_seen        = 1'b0;
      n0                = pres_pc.size();
      dec_redirect      = tbl[i].use_dec;
      dec_redirect_addr = tbl[i].dec_tgt;
      rob_flush         = tbl[i].use_rob;
      rob_flush_addr    = tbl[i].rob_tgt;
      cycle();
      dec_redirect = 1'b0;
      rob_flush    = 1'b0;
      wait_present(60, "scen_word");
      if (pres_pc.size() > n0) chk("scen_next_pc", pres_pc[n0], tbl[i].exp_pc);
      chk("scen_flush_state", {31'h0, flush_seen}, {31'h0, tbl[i].exp_flush});
    end

    // rdy freeze in the middle of a flush, then reset
    ic_lat = 3;
    do_reset(1);
    dec_need_inst = 1'b0;
    run_to_pc(32'h10);
    dec_redirect      = 1'b1;
    dec_redirect_addr = 32'h40;
    cycle();
    dec_redirect = 1'b0;
    chk("t6_flush_addr", ic_addr, 32'h14);
    rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t6_frozen_addr", ic_addr, 32'h14);
      chk("t6_frozen_pc", dec_pc, 32'h40);
      chk("t6_frozen_req", {31'h0, ic_req}, 32'h1);
    end
    rdy = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'h0, dec_inst_valid}, 32'h0);
    chk("t6_rst_addr", ic_addr, RESET_PC);
    cycle();
    rst = 1'b0;
    chk("t6_post_valid", {31'h0, dec_inst_valid}, 32'h0);
    chk("t6_post_addr", ic_addr, RESET_PC);
    pres_pc.delete();
    pres_cyc.delete();
    wait_present(20, "t6_word");
    if (pres_pc.size() > 0) chk("t6_first_pc", pres_pc[0], RESET_PC);

    // randomized traffic against the model
    do_reset(1);
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) ic_lat = $urandom_range(0, 3);
      rst           = ($urandom_range(0, 149) == 0);
      rdy           = ($urandom_range(0, 7) != 0);
      dec_need_inst = ($urandom_range(0, 2) == 0);
      dec_redirect  = ($urandom_range(0, 9) == 0);
      rob_flush     = ($urandom_range(0, 15) == 0);
      ra            = $urandom();
      ra[1:0]       = 2'b00;
      dec_redirect_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ra;
      ra            = $urandom();
      ra[1:0]       = 2'b00;
      rob_flush_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ra;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
